// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c_master front-end arbiter: FSM encoding,
// bus mode constants and the command field widths.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_STANDARD = 2'd0;
    localparam int ADDR_W = 7;
    localparam int REG_W  = 8;

endpackage

// File: rtl/i2c_arbiter_rr.sv
// Combinational round-robin select: first set request at or after ptr,
// wrapping modulo N, returned as one-hot plus binary index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int pos_s;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos_s  = 0;
        for (int k = 0; k < N; k++) begin
            pos_s = int'(ptr) + k;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            if (!valid && req[pos_s]) begin
                valid         = 1'b1;
                onehot[pos_s] = 1'b1;
                idx           = IDX_W'(pos_s);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares a single i2c_master between NUM_REQ requesters: round-robin grant,
// en/busy handshake sequencing, read-data return and done/err pulses.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_mode,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [REG_W*NUM_REQ-1:0]  req_reg,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [DATA_W*NUM_REQ-1:0] req_din,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      m_en,
    output logic [1:0]                m_mode,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [REG_W-1:0]          m_reg,
    output logic                      m_rw,
    output logic [DATA_W-1:0]         m_din,
    input  logic [DATA_W-1:0]         m_dout,
    input  logic                      m_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t              state_r,   state_s;
    logic [NUM_REQ-1:0]  grant_r,   grant_s;
    logic [IDX_W-1:0]    gidx_r,    gidx_s;
    logic [IDX_W-1:0]    ptr_r,     ptr_s;
    logic [CNT_W-1:0]    cnt_r,     cnt_s;
    logic                m_en_r,    m_en_s;
    logic [NUM_REQ-1:0]  done_r,    done_s;
    logic [NUM_REQ-1:0]  err_r,     err_s;
    logic [DATA_W-1:0]   rd_data_r, rd_data_s;
    logic [1:0]          m_mode_r,  m_mode_s;
    logic [ADDR_W-1:0]   m_addr_r,  m_addr_s;
    logic [REG_W-1:0]    m_reg_r,   m_reg_s;
    logic                m_rw_r,    m_rw_s;
    logic [DATA_W-1:0]   m_din_r,   m_din_s;

    logic [NUM_REQ-1:0]  sel_onehot_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic                sel_valid_s;
    int                  sel_int_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (req),
        .ptr    (ptr_r),
        .onehot (sel_onehot_s),
        .idx    (sel_idx_s),
        .valid  (sel_valid_s)
    );

    assign sel_int_s = int'(sel_idx_s);

    // Next-state and next-output logic for the grant/handshake sequencer.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        gidx_s    = gidx_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        m_en_s    = 1'b0;
        done_s    = '0;
        err_s     = '0;
        rd_data_s = rd_data_r;
        m_mode_s  = m_mode_r;
        m_addr_s  = m_addr_r;
        m_reg_s   = m_reg_r;
        m_rw_s    = m_rw_r;
        m_din_s   = m_din_r;
        case (state_r)
            ST_IDLE: begin
                // A busy master here is a leftover from a reset; let it drain.
                if (!m_busy && sel_valid_s) begin
                    grant_s  = sel_onehot_s;
                    gidx_s   = sel_idx_s;
                    m_mode_s = req_mode[sel_int_s*2 +: 2];
                    m_addr_s = req_addr[sel_int_s*ADDR_W +: ADDR_W];
                    m_reg_s  = req_reg[sel_int_s*REG_W +: REG_W];
                    m_rw_s   = req_rw[sel_int_s];
                    m_din_s  = req_din[sel_int_s*DATA_W +: DATA_W];
                    cnt_s    = '0;
                    state_s  = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // The timeout counts cycles with en actually presented to the master.
                if (m_busy) begin
                    state_s = ST_RUN;
                end else if (m_en_r && (cnt_r == CNT_LAST)) begin
                    err_s   = grant_r;
                    state_s = ST_DONE;
                end else begin
                    m_en_s = 1'b1;
                    if (m_en_r) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            ST_RUN: begin
                if (!m_busy) begin
                    rd_data_s = m_dout;
                    done_s    = grant_r;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                grant_s = '0;
                ptr_s   = (gidx_r == IDX_LAST) ? '0 : (gidx_r + IDX_ONE);
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            gidx_r    <= '0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            m_en_r    <= 1'b0;
            done_r    <= '0;
            err_r     <= '0;
            rd_data_r <= '0;
            m_mode_r  <= MODE_STANDARD;
            m_addr_r  <= '0;
            m_reg_r   <= '0;
            m_rw_r    <= 1'b0;
            m_din_r   <= '0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            gidx_r    <= gidx_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            m_en_r    <= m_en_s;
            done_r    <= done_s;
            err_r     <= err_s;
            rd_data_r <= rd_data_s;
            m_mode_r  <= m_mode_s;
            m_addr_r  <= m_addr_s;
            m_reg_r   <= m_reg_s;
            m_rw_r    <= m_rw_s;
            m_din_r   <= m_din_s;
        end
    end

    assign done    = done_r;
    assign err     = err_r;
    assign rd_data = rd_data_r;
    assign grant   = grant_r;
    assign m_en    = m_en_r;
    assign m_mode  = m_mode_r;
    assign m_addr  = m_addr_r;
    assign m_reg   = m_reg_r;
    assign m_rw    = m_rw_r;
    assign m_din   = m_din_r;

endmodule
